// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with EX-stage operand forwarding and selection
//
// Optional feature macro: E_FWD_W_EN (adds W-stage forwarding ports and logic).
//
// Ports:
//   clk, reset (sync, active-low), stall (1 = load a bubble)
//   D_*        : decoded instruction bundle from the D stage
//   M_fwd_*    : M-stage forwarding source (address, data, write enable)
//   W_fwd_*    : W-stage forwarding source (only with E_FWD_W_EN)
//   E_alu_a/b  : forwarded ALU operands; E_aluop registered opcode
//   E_store_data : forwarded rt value for stores
//   E_pc, E_instr, E_wa, E_regwrite, E_rs, E_rt, E_tnew, E_tnew_m, E_valid
module id_ex_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] D_pc,
    input  logic [31:0] D_instr,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [31:0] D_rs_data,
    input  logic [31:0] D_rt_data,
    input  logic [31:0] D_imm,
    input  logic [2:0]  D_aluop,
    input  logic        D_alusrc,
    input  logic        D_regwrite,
    input  logic [4:0]  D_wa,
    input  logic [1:0]  D_tnew,
    input  logic [4:0]  M_fwd_addr,
    input  logic [31:0] M_fwd_data,
    input  logic        M_fwd_we,
`ifdef E_FWD_W_EN
    input  logic [4:0]  W_fwd_addr,
    input  logic [31:0] W_fwd_data,
    input  logic        W_fwd_we,
`endif
    output logic [31:0] E_alu_a,
    output logic [31:0] E_alu_b,
    output logic [2:0]  E_aluop,
    output logic [31:0] E_store_data,
    output logic [31:0] E_pc,
    output logic [31:0] E_instr,
    output logic [4:0]  E_wa,
    output logic        E_regwrite,
    output logic [4:0]  E_rs,
    output logic [4:0]  E_rt,
    output logic [1:0]  E_tnew,
    output logic [1:0]  E_tnew_m,
    output logic        E_valid
);

    // Pipeline state
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [4:0]  r_rs;
    logic [4:0]  r_rt;
    logic [31:0] r_rs_data;
    logic [31:0] r_rt_data;
    logic [31:0] r_imm;
    logic [2:0]  r_aluop;
    logic        r_alusrc;
    logic        r_regwrite;
    logic [4:0]  r_wa;
    logic [1:0]  r_tnew;
    logic        r_valid;

    // Forwarding hits and forwarded operands
    logic        w_m_hit_rs;
    logic        w_m_hit_rt;
    logic [31:0] w_fa;
    logic [31:0] w_fb;

    // Reset and stall both collapse the stage to all-zero contents; the zero
    // encoding decodes as sll $0 with ALU opcode ADD and no register write.
    always_ff @(posedge clk) begin
        if (!reset || stall) begin
            r_pc       <= 32'd0;
            r_instr    <= 32'd0;
            r_rs       <= 5'd0;
            r_rt       <= 5'd0;
            r_rs_data  <= 32'd0;
            r_rt_data  <= 32'd0;
            r_imm      <= 32'd0;
            r_aluop    <= 3'd0;
            r_alusrc   <= 1'b0;
            r_regwrite <= 1'b0;
            r_wa       <= 5'd0;
            r_tnew     <= 2'd0;
            r_valid    <= 1'b0;
        end else begin
            r_pc       <= D_pc;
            r_instr    <= D_instr;
            r_rs       <= D_rs;
            r_rt       <= D_rt;
            r_rs_data  <= D_rs_data;
            r_rt_data  <= D_rt_data;
            r_imm      <= D_imm;
            r_aluop    <= D_aluop;
            r_alusrc   <= D_alusrc;
            r_regwrite <= D_regwrite;
            r_wa       <= D_wa;
            r_tnew     <= D_tnew;
            r_valid    <= 1'b1;
        end
    end

    // $0 is hard-wired zero, so a producer naming $0 must never override it.
    assign w_m_hit_rs = M_fwd_we && (M_fwd_addr == r_rs) && (r_rs != 5'd0);
    assign w_m_hit_rt = M_fwd_we && (M_fwd_addr == r_rt) && (r_rt != 5'd0);

`ifdef E_FWD_W_EN
    logic w_w_hit_rs;
    logic w_w_hit_rt;

    assign w_w_hit_rs = W_fwd_we && (W_fwd_addr == r_rs) && (r_rs != 5'd0);
    assign w_w_hit_rt = W_fwd_we && (W_fwd_addr == r_rt) && (r_rt != 5'd0);
`endif

    // M is the younger producer, so it is applied last and wins over W.
    always_comb begin
        w_fa = r_rs_data;
        w_fb = r_rt_data;
`ifdef E_FWD_W_EN
        if (w_w_hit_rs) w_fa = W_fwd_data;
        if (w_w_hit_rt) w_fb = W_fwd_data;
`endif
        if (w_m_hit_rs) w_fa = M_fwd_data;
        if (w_m_hit_rt) w_fb = M_fwd_data;
    end

    assign E_alu_a      = w_fa;
    assign E_alu_b      = r_alusrc ? r_imm : w_fb;
    assign E_store_data = w_fb;
    assign E_aluop      = r_aluop;
    assign E_pc         = r_pc;
    assign E_instr      = r_instr;
    assign E_wa         = r_wa;
    assign E_regwrite   = r_regwrite & r_valid;
    assign E_rs         = r_rs;
    assign E_rt         = r_rt;
    assign E_tnew       = r_tnew;
    // Saturating decrement: a result already available stays available.
    assign E_tnew_m     = (r_tnew == 2'd0) ? 2'd0 : (r_tnew - 2'd1);
    assign E_valid      = r_valid;

endmodule
